alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Keypad-driven sequencer for a multi-cycle ALU: collects "A op B =" from ASCII keys,
// issues the operation, waits RESULT_LATENCY cycles and latches the result.
module alu_sequencer #(
  parameter int RESULT_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  output logic        key_ready,
  output logic [7:0]  alu_data_a,
  output logic [7:0]  alu_data_b,
  output logic [7:0]  alu_operation,
  input  logic [15:0] alu_result,
  input  logic        alu_overflow,
  output logic [7:0]  result,
  output logic        result_valid,
  output logic        overflow_flag,
  output logic        busy,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int CNT_W = $clog2(RESULT_LATENCY + 1);

  localparam logic [7:0] K_ADD = 8'h2B;
  localparam logic [7:0] K_SUB = 8'h2D;
  localparam logic [7:0] K_MUL = 8'h2A;
  localparam logic [7:0] K_DIV = 8'h2F;
  localparam logic [7:0] K_AND = 8'h26;
  localparam logic [7:0] K_OR  = 8'h7C;
  localparam logic [7:0] K_EQ  = 8'h3D;
  localparam logic [7:0] K_CLR = 8'h43;

  localparam logic [1:0] E_DIV0   = 2'b01;
  localparam logic [1:0] E_RANGE  = 2'b10;
  localparam logic [1:0] E_SYNTAX = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_OP, S_GET_B, S_EXEC, S_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         acc_q, acc_d;
  logic [1:0]         ndig_q, ndig_d;
  logic [7:0]         a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic [7:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               overflow_q, overflow_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               key_ready_q, key_ready_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;
  logic [7:0]         alu_op_q, alu_op_d;

  logic               key_accept, is_digit, is_op, is_eq, is_clr, acc_bad;
  logic [3:0]         digit;
  logic [11:0]        acc_ext;
  logic               unused_alu_hi;

  // Decimal shift-in; 12 bits holds 255*10+9 so the range check never wraps.
  function automatic logic [11:0] acc_mac(input logic [9:0] acc, input logic [3:0] dig);
    return 12'(acc) * 12'd10 + 12'(dig);
  endfunction

  assign unused_alu_hi = ^alu_result[15:8];

  assign key_accept = key_valid && key_ready_q;
  assign is_digit   = (key_data >= 8'h30) && (key_data <= 8'h39);
  assign is_op      = (key_data == K_ADD) || (key_data == K_SUB) || (key_data == K_MUL) ||
                      (key_data == K_DIV) || (key_data == K_AND) || (key_data == K_OR);
  assign is_eq      = (key_data == K_EQ);
  assign is_clr     = (key_data == K_CLR);
  assign digit      = key_data[3:0];
  assign acc_ext    = acc_mac(acc_q, digit);
  assign acc_bad    = (ndig_q == 2'd3) || (acc_ext > 12'd255);

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    ndig_d         = ndig_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    overflow_d     = overflow_q;
    result_valid_d = 1'b0;
    err_code_d     = err_code_q;

    case (state_q)
      S_EXEC: begin
        cnt_d   = CNT_W'(RESULT_LATENCY);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          result_d       = alu_result[7:0];
          overflow_d     = alu_overflow;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (key_accept) begin
          if (is_clr) begin
            state_d    = S_IDLE;
            acc_d      = '0;
            ndig_d     = '0;
            a_d        = '0;
            b_d        = '0;
            op_d       = '0;
            err_code_d = '0;
          end else begin
            case (state_q)
              S_IDLE: begin
                if (is_digit) begin
                  acc_d   = 10'(digit);
                  ndig_d  = 2'd1;
                  state_d = S_GET_A;
                end else if (is_op || is_eq) begin
                  state_d    = S_ERROR;
                  err_code_d = E_SYNTAX;
                end
              end
              S_GET_A: begin
                if (is_digit) begin
                  if (acc_bad) begin
                    state_d    = S_ERROR;
                    err_code_d = E_RANGE;
                  end else begin
                    acc_d  = acc_ext[9:0];
                    ndig_d = ndig_q + 2'd1;
                  end
                end else if (is_op) begin
                  a_d     = acc_q[7:0];
                  op_d    = key_data;
                  state_d = S_GET_OP;
                end else if (is_eq) begin
                  state_d    = S_ERROR;
                  err_code_d = E_SYNTAX;
                end
              end
              S_GET_OP: begin
                if (is_digit) begin
                  acc_d   = 10'(digit);
                  b_d     = 8'(digit);
                  ndig_d  = 2'd1;
                  state_d = S_GET_B;
                end else if (is_op) begin
                  op_d = key_data;
                end else if (is_eq) begin
                  state_d    = S_ERROR;
                  err_code_d = E_SYNTAX;
                end
              end
              S_GET_B: begin
                if (is_digit) begin
                  if (acc_bad) begin
                    state_d    = S_ERROR;
                    err_code_d = E_RANGE;
                  end else begin
                    acc_d  = acc_ext[9:0];
                    b_d    = acc_ext[7:0];
                    ndig_d = ndig_q + 2'd1;
                  end
                end else if (is_op) begin
                  state_d    = S_ERROR;
                  err_code_d = E_SYNTAX;
                end else if (is_eq) begin
                  // A zero divisor is caught here so the ALU never sees it.
                  if ((op_q == K_DIV) && (b_q == 8'd0)) begin
                    state_d    = S_ERROR;
                    err_code_d = E_DIV0;
                  end else begin
                    state_d = S_EXEC;
                  end
                end
              end
              S_DONE: begin
                if (is_digit) begin
                  acc_d   = 10'(digit);
                  ndig_d  = 2'd1;
                  state_d = S_GET_A;
                end else if (is_op) begin
                  if (overflow_q) begin
                    state_d    = S_ERROR;
                    err_code_d = E_SYNTAX;
                  end else begin
                    a_d     = result_q;
                    op_d    = key_data;
                    state_d = S_GET_OP;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    key_ready_d = (state_d != S_EXEC) && (state_d != S_WAIT);
    busy_d      = !key_ready_d;
    error_d     = (state_d == S_ERROR);
    alu_op_d    = busy_d ? op_d : 8'h00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      ndig_q         <= '0;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      err_code_q     <= '0;
      key_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      alu_op_q       <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      ndig_q         <= ndig_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      err_code_q     <= err_code_d;
      key_ready_q    <= key_ready_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
      alu_op_q       <= alu_op_d;
    end
  end

  assign key_ready     = key_ready_q;
  assign alu_data_a    = a_q;
  assign alu_data_b    = b_q;
  assign alu_operation = alu_op_q;
  assign result        = result_q;
  assign result_valid  = result_valid_q;
  assign overflow_flag = overflow_q;
  assign busy          = busy_q;
  assign error         = error_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: pipelined ALU stand-in, key-level reference model checked
// every cycle, directed calculator scenarios, then randomized key traffic.
module tb_alu_sequencer;

  localparam int L = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_data = 8'h00;
  logic        key_ready;
  logic [7:0]  alu_data_a, alu_data_b, alu_operation;
  logic [15:0] alu_result;
  logic        alu_overflow;
  logic [7:0]  result;
  logic        result_valid, overflow_flag, busy, error;
  logic [1:0]  err_code;

  alu_sequencer #(.RESULT_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_data(key_data),
    .key_ready(key_ready), .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
    .alu_operation(alu_operation), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .result(result), .result_valid(result_valid), .overflow_flag(overflow_flag),
    .busy(busy), .error(error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int alu_f(input int a, input int b, input int op);
    int r;
    case (op)
      'h2B: r = a + b;
      'h2D: r = a - b;
      'h2A: r = a * b;
      'h2F: r = (b == 0) ? 0 : a / b;
      'h26: r = a & b;
      'h7C: r = a | b;
      default: r = 0;
    endcase
    return r & 'hFFFF;
  endfunction

  // ALU stand-in with exactly L register stages from operands to result.
  logic [15:0] pipe [L];
  always @(posedge clock) begin
    pipe[0] <= 16'(alu_f(int'(alu_data_a), int'(alu_data_b), int'(alu_operation)));
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_result   = pipe[L-1];
  assign alu_overflow = (pipe[L-1] > 16'd255);

  // Reference model: calculator phases plus a busy countdown for the ALU round trip.
  localparam int PH_IDLE = 0, PH_A = 1, PH_OP = 2, PH_B = 3, PH_DONE = 4, PH_ERR = 5;
  int m_phase, m_acc, m_nd, m_a, m_b, m_op, m_pend, m_exp, m_res, m_ovf, m_rv, m_err;
  bit m_live = 1'b0;

  function automatic void m_fail(input int code);
    m_phase = PH_ERR;
    m_err   = code;
  endfunction

  function automatic void m_digit(input int d, input bit is_b);
    if (m_nd == 3 || m_acc * 10 + d > 255) m_fail(2);
    else begin
      m_acc = m_acc * 10 + d;
      m_nd++;
      if (is_b) m_b = m_acc;
    end
  endfunction

  function automatic void model_key(input int k);
    bit dig, opk, eq;
    int d;
    dig = (k >= 'h30 && k <= 'h39);
    d   = k - 'h30;
    opk = (k == 'h2B || k == 'h2D || k == 'h2A || k == 'h2F || k == 'h26 || k == 'h7C);
    eq  = (k == 'h3D);
    if (k == 'h43) begin
      m_phase = PH_IDLE; m_acc = 0; m_nd = 0; m_a = 0; m_b = 0; m_op = 0; m_err = 0;
      return;
    end
    case (m_phase)
      PH_IDLE, PH_DONE: begin
        if (dig) begin m_acc = d; m_nd = 1; m_phase = PH_A; end
        else if (opk && m_phase == PH_DONE) begin
          if (m_ovf != 0) m_fail(3);
          else begin m_a = m_res; m_op = k; m_phase = PH_OP; end
        end else if ((opk || eq) && m_phase == PH_IDLE) m_fail(3);
      end
      PH_A: begin
        if (dig) m_digit(d, 1'b0);
        else if (opk) begin m_a = m_acc; m_op = k; m_phase = PH_OP; end
        else if (eq) m_fail(3);
      end
      PH_OP: begin
        if (dig) begin m_acc = d; m_nd = 1; m_b = d; m_phase = PH_B; end
        else if (opk) m_op = k;
        else if (eq) m_fail(3);
      end
      PH_B: begin
        if (dig) m_digit(d, 1'b1);
        else if (opk) m_fail(3);
        else if (eq) begin
          if (m_op == 'h2F && m_b == 0) m_fail(1);
          else begin m_pend = L + 1; m_exp = alu_f(m_a, m_b, m_op); end
        end
      end
      default: ;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_phase = PH_IDLE; m_acc = 0; m_nd = 0; m_a = 0; m_b = 0; m_op = 0;
      m_pend = 0; m_exp = 0; m_res = 0; m_ovf = 0; m_rv = 0; m_err = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_rv = 0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          m_res = m_exp & 'hFF; m_ovf = (m_exp > 255) ? 1 : 0; m_rv = 1; m_phase = PH_DONE;
        end
      end else if (key_valid) model_key(int'(key_data));
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      cmp("key_ready", 32'(key_ready), 32'(m_pend == 0));
      cmp("busy", 32'(busy), 32'(m_pend > 0));
      cmp("alu_operation", 32'(alu_operation), (m_pend > 0) ? m_op : 0);
      cmp("result", 32'(result), m_res);
      cmp("result_valid", 32'(result_valid), m_rv);
      cmp("overflow_flag", 32'(overflow_flag), m_ovf);
      cmp("error", 32'(error), 32'(m_phase == PH_ERR));
      cmp("err_code", 32'(err_code), m_err);
      if (m_pend > 0) begin
        cmp("alu_data_a", 32'(alu_data_a), m_a);
        cmp("alu_data_b", 32'(alu_data_b), m_b);
      end
    end
  end

  // Event counters for directed scenarios.
  int busy_cnt = 0, opnz_cnt = 0, mul_cnt = 0, rv_cnt = 0;
  always @(negedge clock) begin
    if (busy === 1'b1) busy_cnt++;
    if (alu_operation !== 8'h00) opnz_cnt++;
    if (busy === 1'b1 && alu_operation === 8'h2A) mul_cnt++;
    if (result_valid === 1'b1) rv_cnt++;
  end

  task automatic send_key(input logic [7:0] k);
    int guard = 0;
    key_valid = 1'b1;
    key_data  = k;
    @(negedge clock);
    while (key_ready !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) cmp("key_accept_timeout", 32'(key_ready), 32'd1);
    @(posedge clock);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_key(s[i]);
  endtask

  // Called right after '=' is accepted; counts cycles to result_valid and key_ready lows.
  task automatic measure(output int lat, output int krlow);
    lat = 1;
    krlow = 0;
    while (result_valid !== 1'b1 && lat < 40) begin
      if (key_ready !== 1'b1) krlow++;
      @(posedge clock);
      #1;
      lat++;
    end
    if (lat >= 40) cmp("result_valid_timeout", 32'(result_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, krlow, snap_a, snap_b, snap_c;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cmp("rst_key_ready", 32'(key_ready), 32'd1);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_error", 32'(error), 32'd0);
    cmp("rst_err_code", 32'(err_code), 32'd0);
    cmp("rst_result", 32'(result), 32'd0);
    cmp("rst_result_valid", 32'(result_valid), 32'd0);
    cmp("rst_alu_operation", 32'(alu_operation), 32'd0);

    send_str("12+34=");
    measure(lat, krlow);
    cmp("add_latency", lat, 2 + L);
    cmp("add_result", 32'(result), 32'h2E);
    cmp("add_overflow", 32'(overflow_flag), 32'd0);

    send_str("-6=");
    measure(lat, krlow);
    cmp("sub_result", 32'(result), 32'h28);
    cmp("sub_key_ready_low", krlow, L + 1);
    send_key("C");
    cmp("clr_keeps_result", 32'(result), 32'h28);
    cmp("clr_error", 32'(error), 32'd0);

    snap_a = mul_cnt;
    send_str("200*2=");
    measure(lat, krlow);
    cmp("mul_op_cycles", mul_cnt - snap_a, L + 1);
    cmp("mul_result", 32'(result), 32'h90);
    cmp("mul_overflow", 32'(overflow_flag), 32'd1);
    send_key("+");
    cmp("chain_ovf_error", 32'(error), 32'd1);
    cmp("chain_ovf_code", 32'(err_code), 32'd3);

    send_key("C");
    snap_a = busy_cnt;
    snap_b = opnz_cnt;
    send_str("9/0=");
    cmp("div0_error", 32'(error), 32'd1);
    cmp("div0_code", 32'(err_code), 32'd1);
    repeat (4) @(posedge clock);
    #1;
    cmp("div0_busy_never", busy_cnt - snap_a, 0);
    cmp("div0_op_zero", opnz_cnt - snap_b, 0);
    send_key("C");
    cmp("div0_clr_error", 32'(error), 32'd0);
    cmp("div0_clr_code", 32'(err_code), 32'd0);

    send_str("25");
    cmp("range_2dig_ok", 32'(error), 32'd0);
    send_key("6");
    cmp("range_256_code", 32'(err_code), 32'd2);
    send_key("C");
    send_str("123");
    cmp("range_3dig_ok", 32'(error), 32'd0);
    send_key("4");
    cmp("range_4dig_code", 32'(err_code), 32'd2);
    send_key("C");

    send_str("5+5=");
    @(posedge clock);
    #1;
    cmp("wait_busy", 32'(busy), 32'd1);
    snap_c = rv_cnt;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cmp("midwait_key_ready", 32'(key_ready), 32'd1);
    cmp("midwait_busy", 32'(busy), 32'd0);
    cmp("midwait_result", 32'(result), 32'd0);
    cmp("midwait_alu_a", 32'(alu_data_a), 32'd0);
    cmp("midwait_alu_op", 32'(alu_operation), 32'd0);
    repeat (L + 3) @(posedge clock);
    #1;
    cmp("midwait_no_pulse", rv_cnt - snap_c, 0);

    for (int i = 0; i < 4000; i++) begin
      int r;
      @(posedge clock);
      #1;
      reset = ($urandom_range(0, 199) == 0);
      key_valid = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 50)      key_data = 8'(8'h30 + $urandom_range(0, 9));
      else if (r < 68) begin
        case ($urandom_range(0, 5))
          0: key_data = 8'h2B;
          1: key_data = 8'h2D;
          2: key_data = 8'h2A;
          3: key_data = 8'h2F;
          4: key_data = 8'h26;
          default: key_data = 8'h7C;
        endcase
      end
      else if (r < 80) key_data = 8'h3D;
      else if (r < 87) key_data = 8'h43;
      else             key_data = 8'($urandom_range(0, 255));
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    key_valid = 1'b0;
    repeat (L + 4) @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
